vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator that drives the VGA sync outputs and the pixel-coordinate/blanking bus consumed by `grid_controller` and the downstream pixel-colour logic. It runs on the pixel clock and produces `HS`, `VS`, `hcounter`, `vcounter` and `blank` as registered, mutually aligned signals. It also produces frame/line markers and a frame counter for game-tick logic. Defaults give 640x480 at 60 Hz from a 25 MHz `pixel_clk`.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_ACTIVE, 1'b0, level of `HS` during sync
- VS_ACTIVE, 1'b0, level of `VS` during sync

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- hcounter  out  11  current pixel column, 0..H_TOTAL-1
- vcounter  out  11  current line, 0..V_TOTAL-1
- blank  out  1  1 when (hcounter, vcounter) is outside the visible area
- line_start  out  1  one-cycle pulse, hcounter==0 after a line wrap
- frame_start  out  1  one-cycle pulse, counters==(0,0) after a frame wrap
- frame_count  out  8  frames completed since reset, modulo 256

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is computed the same way (default 525). Both totals must be ≤2048.
- hcounter increments by 1 on every cycle. At H_TOTAL-1 it wraps to 0, and on that same edge vcounter increments.
- vcounter wraps V_TOTAL-1 → 0 on the edge where hcounter also wraps.
- HS = HS_ACTIVE iff H_VISIBLE+H_FRONT ≤ hcounter < H_VISIBLE+H_FRONT+H_SYNC. Default range is 656..751.
- VS = VS_ACTIVE iff V_VISIBLE+V_FRONT ≤ vcounter < V_VISIBLE+V_FRONT+V_SYNC. Default range is 490..491, over whole lines.
- blank = (hcounter ≥ H_VISIBLE) | (vcounter ≥ V_VISIBLE).
- line_start = 1 exactly on cycles where hcounter==0 was reached by a wrap.
- frame_start = 1 exactly on cycles where (0,0) was reached by a frame wrap. Every frame_start cycle is also a line_start cycle.
- frame_count increments, wrapping 255→0, on the same edge that raises frame_start.
- Every output is a flop. HS, VS, blank and the pulses are computed from next-state counter values, so each output describes the same (hcounter, vcounter) shown in that cycle. There is no skew between outputs.

Reset values (rst high at a rising edge):
- hcounter=0, vcounter=0, frame_count=0
- HS=~HS_ACTIVE, VS=~VS_ACTIVE
- blank=0, because (0,0) is visible
- line_start=0, frame_start=0: the reset state is not a wrap

## Timing
- While rst is high, all outputs hold their reset values.
- On the first edge with rst low, counters advance to (1,0).
- Reset mid-frame forces the reset values on the next edge with no partial-line completion. frame_count is cleared.
- A line is H_TOTAL cycles and a frame is H_TOTAL*V_TOTAL cycles; defaults are 800 and 420000 cycles.
- HS asserts on the cycle hcounter shows 656 and deasserts on the cycle it shows 752.
- VS asserts on the cycle showing (0,490) and deasserts on the cycle showing (0,492).
- line_start and frame_start are exactly one cycle wide and never asserted back-to-back.

## Test plan
- Reset: hold rst 3 cycles, then release. Required: reset values as listed; 1 cycle after release hcounter=1, vcounter=0, HS=1, VS=1, blank=0, pulses 0.
- HS/blank edges: run from reset to line 0. Required:
  - blank rises at hcounter=640
  - HS goes low at 656 and returns high at 752
  - at 799→0: line_start=1, vcounter=1, blank=0
- VS and vertical blank: run to line 480. Required:
  - blank=1 on every pixel of lines 480..524
  - VS low exactly from (0,490) through (799,491), i.e. 1600 cycles
- Frame wrap: at (799,524) → next cycle (0,0) with frame_start=1, line_start=1 and frame_count=1. Both pulses are 0 the following cycle. The next frame_start comes 420000 cycles later.
- frame_count wrap: run 256 frames. Required: frame_count=255 after the 255th wrap and 0 after the 256th.
- Reset mid-operation: assert rst at (300,200) with frame_count=3. Required: next edge gives (0,0), frame_count=0, frame_start=0; after release, the full line and frame timing repeat exactly.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters, HS/VS syncs, blanking, line/frame markers, frame counter.
// Latency: every output is a flop computed from next-state counters, so all outputs describe the same pixel.
// Backpressure: none; free-running on pixel_clk, synchronous active-high rst returns to pixel (0,0).
//
// Ports:
//   pixel_clk   - pixel clock, all state on rising edge
//   rst         - synchronous reset, active high
//   HS, VS      - horizontal / vertical sync (levels set by HS_ACTIVE / VS_ACTIVE)
//   hcounter    - current column 0..H_TOTAL-1
//   vcounter    - current line   0..V_TOTAL-1
//   blank       - 1 outside the visible area
//   line_start  - one-cycle pulse on the cycle hcounter wrapped to 0
//   frame_start - one-cycle pulse on the cycle the counters wrapped to (0,0)
//   frame_count - frames completed since reset, modulo 256
//
// Both H_TOTAL and V_TOTAL must not exceed 2048 so the counters fit in 11 bits.

module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        HS_ACTIVE = 1'b0,
    parameter logic        VS_ACTIVE = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        rst,
    output logic        HS,
    output logic        VS,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last counter values before a wrap.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Region bounds are kept 12 bits wide: a sync end can equal 2048 when
    // the back porch is zero and the total is at its maximum.
    localparam logic [11:0] H_VIS_END   = 12'(H_VISIBLE);
    localparam logic [11:0] HS_BEGIN    = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END      = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_VIS_END   = 12'(V_VISIBLE);
    localparam logic [11:0] VS_BEGIN    = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END      = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] h_next_ext;
    logic [11:0] v_next_ext;

    always_comb begin
        h_wrap = (hcount_q == H_LAST);
        // A frame only wraps on the same edge that closes the last line.
        v_wrap = h_wrap && (vcount_q == V_LAST);

        hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;

        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
        end

        frame_count_d = v_wrap ? frame_count_q + 8'd1 : frame_count_q;

        // Decode from the next-state counters so the registered syncs,
        // blank and pulses line up with the registered counters.
        h_next_ext = {1'b0, hcount_d};
        v_next_ext = {1'b0, vcount_d};

        hs_d = ((h_next_ext >= HS_BEGIN) && (h_next_ext < HS_END)) ? HS_ACTIVE : ~HS_ACTIVE;
        vs_d = ((v_next_ext >= VS_BEGIN) && (v_next_ext < VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
        blank_d = (h_next_ext >= H_VIS_END) || (v_next_ext >= V_VIS_END);

        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            frame_count_q <= 8'd0;
            hs_q          <= ~HS_ACTIVE;
            vs_q          <= ~VS_ACTIVE;
            // (0,0) is visible, and the reset state is not a wrap.
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcounter    = hcount_q;
    assign vcounter    = vcount_q;
    assign frame_count = frame_count_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so many frames fit in a short run.
// Geometry: H = 10 visible, 2 front, 3 sync, 2 back (17 total); V = 6, 1, 2, 2 (11 total).
// HS low at h 12..14, VS low on lines 7..8, blank at h>=10 or v>=6, frame = 187 cycles.

module tb_vga_timing_gen;

    logic        pixel_clk;
    logic        rst;
    logic        HS;
    logic        VS;
    logic [10:0] hcounter;
    logic [10:0] vcounter;
    logic        blank;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .H_VISIBLE (10),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (2),
        .HS_ACTIVE (1'b0),
        .VS_ACTIVE (1'b0)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .HS          (HS),
        .VS          (VS),
        .hcounter    (hcounter),
        .vcounter    (vcounter),
        .blank       (blank),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Advance one pixel and sample 1 time unit after the edge.
    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // Walk to pixel (h,v) within a bounded number of cycles; the final check
    // confirms the position was reached.
    task automatic goto(input string tag, input int h, input int v);
        int n;
        n = 0;
        while (!(hcounter == 11'(h) && vcounter == 11'(v)) && n < 400) begin
            step();
            n++;
        end
        check_eq(tag, {vcounter, 5'd0, hcounter}, {11'(v), 5'd0, 11'(h)});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_h"},  32'(hcounter),    32'd0);
        check_eq({tag, "_v"},  32'(vcounter),    32'd0);
        check_eq({tag, "_hs"}, 32'(HS),          32'd1);
        check_eq({tag, "_vs"}, 32'(VS),          32'd1);
        check_eq({tag, "_bl"}, 32'(blank),       32'd0);
        check_eq({tag, "_ls"}, 32'(line_start),  32'd0);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
        check_eq({tag, "_fc"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        int n;
        int hs_low, vs_low, bl_cnt, ls_cnt, fs_cnt, fs_idx, bad_vblank, bad_vs, b2b;
        logic prev_ls;

        // ---------------- reset ----------------
        rst = 1'b1;
        step(); step(); step();
        check_reset_state("rst");

        rst = 1'b0;
        step();
        check_eq("rel_h",  32'(hcounter),    32'd1);
        check_eq("rel_v",  32'(vcounter),    32'd0);
        check_eq("rel_hs", 32'(HS),          32'd1);
        check_eq("rel_vs", 32'(VS),          32'd1);
        check_eq("rel_bl", 32'(blank),       32'd0);
        check_eq("rel_ls", 32'(line_start),  32'd0);
        check_eq("rel_fs", 32'(frame_start), 32'd0);

        // ---------------- line 0: blank and HS edges ----------------
        for (int h = 2; h <= 16; h++) begin
            step();
            check_eq("l0_h",  32'(hcounter), 32'(h));
            check_eq("l0_bl", 32'(blank),    (h >= 10) ? 32'd1 : 32'd0);
            check_eq("l0_hs", 32'(HS),       (h >= 12 && h <= 14) ? 32'd0 : 32'd1);
        end
        step();
        check_eq("lw_h",  32'(hcounter),    32'd0);
        check_eq("lw_v",  32'(vcounter),    32'd1);
        check_eq("lw_ls", 32'(line_start),  32'd1);
        check_eq("lw_fs", 32'(frame_start), 32'd0);
        check_eq("lw_bl", 32'(blank),       32'd0);
        step();
        check_eq("lw1_ls", 32'(line_start), 32'd0);

        // ---------------- vertical blank and VS ----------------
        goto("to_16_5", 16, 5);
        check_eq("v5_bl", 32'(blank), 32'd1);
        step();
        check_eq("v6_bl", 32'(blank), 32'd1);
        check_eq("v6_ls", 32'(line_start), 32'd1);
        goto("to_16_6", 16, 6);
        check_eq("v6e_vs", 32'(VS), 32'd1);
        step();
        check_eq("vs_on_v",  32'(vcounter), 32'd7);
        check_eq("vs_on",    32'(VS),       32'd0);
        goto("to_16_8", 16, 8);
        check_eq("vs_last",  32'(VS), 32'd0);
        step();
        check_eq("vs_off",   32'(VS), 32'd1);
        check_eq("vs_off_bl", 32'(blank), 32'd1);

        // ---------------- frame wrap ----------------
        goto("to_16_10", 16, 10);
        check_eq("fw_pre_fs", 32'(frame_start), 32'd0);
        step();
        check_eq("fw_h",  32'(hcounter),    32'd0);
        check_eq("fw_v",  32'(vcounter),    32'd0);
        check_eq("fw_fs", 32'(frame_start), 32'd1);
        check_eq("fw_ls", 32'(line_start),  32'd1);
        check_eq("fw_fc", 32'(frame_count), 32'd1);
        check_eq("fw_bl", 32'(blank),       32'd0);
        step();
        check_eq("fw1_fs", 32'(frame_start), 32'd0);
        check_eq("fw1_ls", 32'(line_start),  32'd0);

        // ---------------- one full frame of aggregate counts ----------------
        hs_low = 0; vs_low = 0; bl_cnt = 0; ls_cnt = 0; fs_cnt = 0; fs_idx = -1;
        bad_vblank = 0; bad_vs = 0; b2b = 0; prev_ls = line_start;
        for (int i = 0; i < 187; i++) begin
            step();
            if (!HS) hs_low++;
            if (!VS) vs_low++;
            if (blank) bl_cnt++;
            if (line_start) ls_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_idx = i;
            end
            if (vcounter >= 11'd6 && !blank) bad_vblank++;
            if (!VS && !(vcounter == 11'd7 || vcounter == 11'd8)) bad_vs++;
            if (line_start && prev_ls) b2b++;
            prev_ls = line_start;
        end
        check_eq("fr_hs_low",  32'(hs_low),     32'd33);
        check_eq("fr_vs_low",  32'(vs_low),     32'd34);
        check_eq("fr_blank",   32'(bl_cnt),     32'd127);
        check_eq("fr_ls",      32'(ls_cnt),     32'd11);
        check_eq("fr_fs",      32'(fs_cnt),     32'd1);
        check_eq("fr_fs_idx",  32'(fs_idx),     32'd185);
        check_eq("fr_vblank",  32'(bad_vblank), 32'd0);
        check_eq("fr_vs_rng",  32'(bad_vs),     32'd0);
        check_eq("fr_b2b",     32'(b2b),        32'd0);
        check_eq("fr_fc",      32'(frame_count), 32'd2);
        check_eq("fr_end_h",   32'(hcounter),   32'd1);

        // ---------------- frame_count wrap ----------------
        n = 0;
        while (frame_count != 8'd255 && n < 60000) begin
            step();
            n++;
        end
        check_eq("fc_255",    32'(frame_count), 32'd255);
        check_eq("fc_255_fs", 32'(frame_start), 32'd1);
        n = 0;
        step();
        n++;
        while (!frame_start && n < 400) begin
            step();
            n++;
        end
        check_eq("fc_wrap",     32'(frame_count), 32'd0);
        check_eq("fc_wrap_per", 32'(n),           32'd187);

        // ---------------- reset mid-operation ----------------
        n = 0;
        while (frame_count != 8'd3 && n < 1000) begin
            step();
            n++;
        end
        check_eq("mid_fc3", 32'(frame_count), 32'd3);
        goto("to_5_3", 5, 3);
        rst = 1'b1;
        step();
        check_reset_state("mid");
        step();
        check_eq("mid_hold_h", 32'(hcounter), 32'd0);
        rst = 1'b0;
        step();
        check_eq("mid_rel_h", 32'(hcounter), 32'd1);
        check_eq("mid_rel_v", 32'(vcounter), 32'd0);
        n = 0;
        while (!line_start && n < 400) begin
            step();
            n++;
        end
        check_eq("mid_line_len", 32'(n), 32'd16);
        check_eq("mid_line_v",   32'(vcounter), 32'd1);
        n = 0;
        while (!frame_start && n < 400) begin
            step();
            n++;
        end
        check_eq("mid_frame_len", 32'(n), 32'd170);
        check_eq("mid_frame_fc",  32'(frame_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
